// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM encoding, status
// counter width and a saturating increment helper.
package clk_rst_seq_pkg;

    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync2.sv
// Two-flop synchroniser, parametrised width, synchronous reset to zero.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// PLL reset / lock-wait / staged reset release sequencer with timeout retry,
// lock-loss recovery and soft restart of the release stages.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int N_OUT          = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 256,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STAGE_GAP      = 16,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              soft_req,
    output logic              pll_resetb,
    output logic [N_OUT-1:0]  rst_out,
    output logic              ready,
    output logic [STAT_W-1:0] retry_cnt,
    output logic [STAT_W-1:0] loss_cnt
);

    localparam int STG_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stab;
    logic [STG_W-1:0] stg;
    logic             lock_s;
    logic             lock_d;
    logic             active;
    logic             lock_lost;

    sync2 #(.W(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign active    = (state == RELEASE) || (state == RUN);
    // Two consecutive low samples filter single-cycle LOCK glitches.
    assign lock_lost = active && !lock_s && !lock_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            stab       <= '0;
            stg        <= '0;
            lock_d     <= 1'b0;
            pll_resetb <= 1'b0;
            rst_out    <= '1;
            ready      <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            lock_d <= lock_s;
            if (lock_lost) begin
                state      <= PLL_RST;
                cnt        <= '0;
                stab       <= '0;
                stg        <= '0;
                pll_resetb <= 1'b0;
                rst_out    <= '1;
                ready      <= 1'b0;
                loss_cnt   <= sat_inc(loss_cnt);
            end else if (soft_req && active) begin
                // Restart only the release stages; the PLL keeps running.
                state   <= RELEASE;
                cnt     <= '0;
                stg     <= '0;
                rst_out <= '1;
                ready   <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                            state      <= WAIT_LOCK;
                            cnt        <= '0;
                            stab       <= '0;
                            pll_resetb <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        stab <= lock_s ? stab + 1'b1 : '0;
                        // Stable lock takes precedence over a coincident timeout.
                        if (lock_s && stab == CNT_W'(LOCK_STABLE - 1)) begin
                            state <= RELEASE;
                            cnt   <= '0;
                            stg   <= '0;
                        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            state      <= PLL_RST;
                            cnt        <= '0;
                            pll_resetb <= 1'b0;
                            retry_cnt  <= sat_inc(retry_cnt);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                            rst_out[stg] <= 1'b0;
                            cnt          <= '0;
                            if (stg == STG_W'(N_OUT - 1)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end else begin
                                stg <= stg + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench: stimulus queues the expected output snapshot and cycle of
// every output change; a negedge monitor pops and compares on each change.
module tb_clk_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       soft_req;
    logic       pll_resetb;
    logic [2:0] rst_out;
    logic       ready;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    clk_rst_seq #(
        .N_OUT(3), .PLL_RST_CYCLES(4), .LOCK_STABLE(8),
        .LOCK_TIMEOUT(32), .STAGE_GAP(2), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .soft_req   (soft_req),
        .pll_resetb (pll_resetb),
        .rst_out    (rst_out),
        .ready      (ready),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    typedef struct {
        int         cyc;
        logic [20:0] snap;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [20:0] prev = 'x;
    logic [20:0] cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic pr, input logic [2:0] ro,
                        input logic rdy, input logic [7:0] rc, input logic [7:0] lc);
        exp_t e;
        e.cyc  = c;
        e.snap = {pr, ro, rdy, rc, lc};
        exp_q.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drops rst one cycle after it was sampled high; returns that cycle as base.
    task automatic rel(output int b);
        @(posedge clk);
        #1;
        b   = cyc;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        cur = {pll_resetb, rst_out, ready, retry_cnt, loss_cnt};
        if (cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.snap !== cur) begin
                    n_mis++;
                    $display("FAIL out_change cyc=%0d got=%h expected cyc=%0d val=%h",
                             cyc, cur, e.cyc, e.snap);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int b, t, r, s1, u, w, g, g2;
        rst = 1'b1; pll_lock = 1'b1; soft_req = 1'b0;
        push(1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);

        // Nominal bring-up with lock tied high
        rel(b);
        push(b+4,  1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
        push(b+14, 1'b1, 3'b110, 1'b0, 8'd0, 8'd0);
        push(b+16, 1'b1, 3'b100, 1'b0, 8'd0, 8'd0);
        push(b+18, 1'b1, 3'b000, 1'b1, 8'd0, 8'd0);

        // One-cycle LOCK glitch in RUN: no change expected
        goto(b+22); pll_lock = 1'b0;
        goto(b+23); pll_lock = 1'b1;

        // Two-cycle LOCK loss in RUN, then full sequence; soft_req in PLL_RST ignored
        t = b + 28;
        push(t+4,  1'b0, 3'b111, 1'b0, 8'd0, 8'd1);
        push(t+8,  1'b1, 3'b111, 1'b0, 8'd0, 8'd1);
        push(t+18, 1'b1, 3'b110, 1'b0, 8'd0, 8'd1);
        push(t+20, 1'b1, 3'b100, 1'b0, 8'd0, 8'd1);
        push(t+22, 1'b1, 3'b000, 1'b1, 8'd0, 8'd1);
        goto(t);   pll_lock = 1'b0;
        goto(t+2); pll_lock = 1'b1;
        goto(t+5); soft_req = 1'b1;
        goto(t+6); soft_req = 1'b0;

        // soft_req in RUN, then again mid-RELEASE after 110
        r  = t + 22;
        s1 = r + 3;
        push(s1+1,  1'b1, 3'b111, 1'b0, 8'd0, 8'd1);
        push(s1+3,  1'b1, 3'b110, 1'b0, 8'd0, 8'd1);
        push(s1+5,  1'b1, 3'b111, 1'b0, 8'd0, 8'd1);
        push(s1+7,  1'b1, 3'b110, 1'b0, 8'd0, 8'd1);
        push(s1+9,  1'b1, 3'b100, 1'b0, 8'd0, 8'd1);
        push(s1+11, 1'b1, 3'b000, 1'b1, 8'd0, 8'd1);
        goto(s1);   soft_req = 1'b1;
        goto(s1+1); soft_req = 1'b0;
        goto(s1+4); soft_req = 1'b1;
        goto(s1+5); soft_req = 1'b0;

        // rst in RUN, then lock held low: timeout retries up to saturation
        u = s1 + 14;
        push(u+1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0);
        goto(u); rst = 1'b1; pll_lock = 1'b0;
        rel(b);
        push(b+4, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k <= 257; k++) begin
            push(b+36*k,   1'b0, 3'b111, 1'b0, 8'((k > 255) ? 255 : k), 8'd0);
            push(b+36*k+4, 1'b1, 3'b111, 1'b0, 8'((k > 255) ? 255 : k), 8'd0);
        end

        // rst mid-WAIT_LOCK, then glitchy lock settling high
        w = b + 36*257 + 10;
        goto(w);
        push(w+1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0);
        rst = 1'b1;
        rel(g);
        pll_lock = 1'b1;
        push(g+4,  1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
        push(g+32, 1'b1, 3'b110, 1'b0, 8'd0, 8'd0);
        push(g+34, 1'b1, 3'b100, 1'b0, 8'd0, 8'd0);
        push(g+36, 1'b1, 3'b000, 1'b1, 8'd0, 8'd0);
        goto(g+5);  pll_lock = 1'b0;
        goto(g+10); pll_lock = 1'b1;
        goto(g+15); pll_lock = 1'b0;
        goto(g+20); pll_lock = 1'b1;

        // Stable lock coinciding with the timeout cycle: lock wins
        goto(g+40);
        push(g+41, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0);
        rst = 1'b1; pll_lock = 1'b0;
        rel(g2);
        push(g2+4,  1'b1, 3'b111, 1'b0, 8'd0, 8'd0);
        push(g2+38, 1'b1, 3'b110, 1'b0, 8'd0, 8'd0);
        push(g2+40, 1'b1, 3'b100, 1'b0, 8'd0, 8'd0);
        push(g2+42, 1'b1, 3'b000, 1'b1, 8'd0, 8'd0);
        goto(g2+26); pll_lock = 1'b1;
        goto(g2+50);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL missing_change expected cyc=%0d val=%h got none", e.cyc, e.snap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
